// File: rtl/fp_mul_add.sv
// Single-cycle binary32 multiply/add unit with a registered result; subnormals flush to zero.
// Optional exception flags output is enabled by defining FP_MUL_ADD_FLAGS_EN.
module fp_mul_add (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
`ifdef FP_MUL_ADD_FLAGS_EN
    output logic [4:0]  flags,
`endif
    output logic [31:0] out
);

    localparam logic [31:0] CanonNan = 32'h7FC00000;

    logic        s1, s2;
    logic [7:0]  e1, e2;
    logic [22:0] f1, f2;
    logic        nan1, nan2, inf1, inf2, zero1, zero2;

    assign {s1, e1, f1} = rs1;
    assign {s2, e2, f2} = rs2;
    assign nan1  = (e1 == 8'hFF) && (f1 != 23'd0);
    assign nan2  = (e2 == 8'hFF) && (f2 != 23'd0);
    assign inf1  = (e1 == 8'hFF) && (f1 == 23'd0);
    assign inf2  = (e2 == 8'hFF) && (f2 == 23'd0);
    assign zero1 = (e1 == 8'd0);
    assign zero2 = (e2 == 8'd0);

    // Multiply path
    logic [47:0] prod;
    logic [9:0]  mul_exp;
    logic [23:0] mul_mant;
    logic        mul_g, mul_s;

    always_comb begin
        prod    = {24'd0, 1'b1, f1} * {24'd0, 1'b1, f2};
        mul_exp = {2'b00, e1} + {2'b00, e2} - 10'd127 + {9'd0, prod[47]};
        if (prod[47]) begin
            mul_mant = prod[47:24];
            mul_g    = prod[23];
            mul_s    = |prod[22:0];
        end else begin
            mul_mant = prod[46:23];
            mul_g    = prod[22];
            mul_s    = |prod[21:0];
        end
    end

    // Add path: A is the larger magnitude; B carries 3 extra bits (guard, round, sticky)
    logic        swap, sa, eff_sub;
    logic [7:0]  ea, eb, ediff;
    logic [23:0] ma, mb;
    logic [4:0]  dsat;
    logic [26:0] b_full, b_sh, b_al;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [26:0] norm;
    logic [9:0]  add_exp;
    logic [23:0] add_mant;
    logic        add_g, add_s;

    always_comb begin
        swap    = {e2, f2} > {e1, f1};
        sa      = swap ? s2 : s1;
        ea      = swap ? e2 : e1;
        eb      = swap ? e1 : e2;
        ma      = {1'b1, swap ? f2 : f1};
        mb      = {1'b1, swap ? f1 : f2};
        eff_sub = s1 ^ s2;
        ediff   = ea - eb;
        dsat    = (ediff > 8'd26) ? 5'd26 : ediff[4:0];
        b_full  = {mb, 3'b000};
        b_sh    = b_full >> dsat;
        b_al    = {b_sh[26:1], b_sh[0] | (|(b_full & ~(27'h7FFFFFF << dsat)))};
        sum     = eff_sub ? ({1'b0, ma, 3'b000} - {1'b0, b_al})
                          : ({1'b0, ma, 3'b000} + {1'b0, b_al});
        lz = 5'd0;
        for (int i = 0; i <= 26; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
        norm = sum[26:0] << lz;
        if (sum[27]) begin
            add_mant = sum[27:4];
            add_g    = sum[3];
            add_s    = |sum[2:0];
            add_exp  = {2'b00, ea} + 10'd1;
        end else begin
            add_mant = norm[26:3];
            add_g    = norm[2];
            add_s    = |norm[1:0];
            add_exp  = {2'b00, ea} - {5'd0, lz};
        end
    end

    // Shared round-to-nearest-even and range check
    logic        pre_sign, pre_g, pre_s, ovf, unf;
    logic [9:0]  pre_exp, exp_r;
    logic [23:0] pre_mant;
    logic [24:0] mant_r;
    logic [31:0] rnd_val;

    always_comb begin
        pre_sign = op ? (s1 ^ s2) : sa;
        pre_exp  = op ? mul_exp : add_exp;
        pre_mant = op ? mul_mant : add_mant;
        pre_g    = op ? mul_g : add_g;
        pre_s    = op ? mul_s : add_s;
        mant_r   = {1'b0, pre_mant} + {24'd0, pre_g & (pre_s | pre_mant[0])};
        exp_r    = pre_exp + {9'd0, mant_r[24]};
        ovf      = $signed(exp_r) >= 10'sd255;
        unf      = $signed(exp_r) <= 10'sd0;
        if (ovf) begin
            rnd_val = {pre_sign, 8'hFF, 23'd0};
        end else if (unf) begin
            rnd_val = {pre_sign, 31'd0};
        end else begin
            rnd_val = {pre_sign, exp_r[7:0], mant_r[24] ? mant_r[23:1] : mant_r[22:0]};
        end
    end

    // Special operands and exact cancellation bypass the rounder
    logic        spec_hit;
    logic [31:0] spec_val;
`ifdef FP_MUL_ADD_FLAGS_EN
    logic        spec_nv, snan;
    assign snan = (nan1 && !f1[22]) || (nan2 && !f2[22]);
`endif

    always_comb begin
        spec_hit = 1'b1;
        spec_val = CanonNan;
`ifdef FP_MUL_ADD_FLAGS_EN
        spec_nv  = 1'b0;
`endif
        if (nan1 || nan2) begin
`ifdef FP_MUL_ADD_FLAGS_EN
            spec_nv = snan;
`endif
        end else if (op) begin
            if ((inf1 && zero2) || (zero1 && inf2)) begin
`ifdef FP_MUL_ADD_FLAGS_EN
                spec_nv = 1'b1;
`endif
            end else if (inf1 || inf2) begin
                spec_val = {s1 ^ s2, 8'hFF, 23'd0};
            end else if (zero1 || zero2) begin
                spec_val = {s1 ^ s2, 31'd0};
            end else begin
                spec_hit = 1'b0;
            end
        end else begin
            if (inf1 && inf2 && (s1 != s2)) begin
`ifdef FP_MUL_ADD_FLAGS_EN
                spec_nv = 1'b1;
`endif
            end else if (inf1) begin
                spec_val = rs1;
            end else if (inf2) begin
                spec_val = rs2;
            end else if (zero1 && zero2) begin
                spec_val = {s1 & s2, 31'd0};
            end else if (zero1) begin
                spec_val = rs2;
            end else if (zero2) begin
                spec_val = rs1;
            end else if (sum == 28'd0) begin
                spec_val = 32'd0;
            end else begin
                spec_hit = 1'b0;
            end
        end
    end

    logic [31:0] out_d, out_q;
    assign out_d = spec_hit ? spec_val : rnd_val;
    assign out   = out_q;

`ifdef FP_MUL_ADD_FLAGS_EN
    logic [4:0] flags_d, flags_q;
    assign flags_d = spec_hit ? {spec_nv, 4'b0000}
                              : {2'b00, ovf, unf, ovf | unf | pre_g | pre_s};
    assign flags   = flags_q;

    always_ff @(posedge clk) begin
        if (resetn) flags_q <= 5'd0;
        else        flags_q <= flags_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (resetn) out_q <= 32'd0;
        else        out_q <= out_d;
    end

endmodule

// File: tb/tb_fp_mul_add.sv
// Self-checking bench for fp_mul_add: directed cases plus randomized operands checked
// against an exact-arithmetic reference model.
module tb_fp_mul_add;

    logic        clk = 1'b0;
    logic        resetn, op;
    logic [31:0] rs1, rs2, out;
`ifdef FP_MUL_ADD_FLAGS_EN
    logic [4:0]  flags;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_mul_add dut (
        .clk    (clk),
        .resetn (resetn),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
`ifdef FP_MUL_ADD_FLAGS_EN
        .flags  (flags),
`endif
        .out    (out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round an exact magnitude mag * 2^exp_lsb to binary32; returns {flags, value}.
    function automatic logic [36:0] round_pack(input logic sign, input logic [299:0] mag,
                                               input int exp_lsb);
        int          p;
        int          e;
        logic [299:0] kept, rem, half;
        logic        nx;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p > 23) begin
            int sh;
            sh   = p - 23;
            kept = mag >> sh;
            rem  = mag & ((300'd1 << sh) - 300'd1);
            half = 300'd1 << (sh - 1);
            if (rem > half || (rem == half && kept[0])) kept = kept + 300'd1;
            nx = (rem != '0);
        end else begin
            kept = mag << (23 - p);
            nx   = 1'b0;
        end
        e = p + exp_lsb + 127;
        if (kept[24]) begin
            kept = kept >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {5'b00101, sign, 8'hFF, 23'd0};
        if (e <= 0)   return {5'b00011, sign, 31'd0};
        return {4'b0000, nx, sign, e[7:0], kept[22:0]};
    endfunction

    function automatic logic [36:0] ref_model(input logic mop, input logic [31:0] a,
                                              input logic [31:0] b);
        int           ea, eb, lo;
        logic         sa, sb, na, nb, ia, ib, za, zb, sn;
        logic [299:0] aw, bw;
        sa = a[31]; sb = b[31];
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        za = (ea == 0);
        zb = (eb == 0);
        sn = (na && !a[22]) || (nb && !b[22]);
        if (na || nb) return {sn, 4'b0000, 32'h7FC00000};
        aw = '0; aw[23:0] = {1'b1, a[22:0]};
        bw = '0; bw[23:0] = {1'b1, b[22:0]};
        if (mop) begin
            if ((ia && zb) || (za && ib)) return {5'b10000, 32'h7FC00000};
            if (ia || ib) return {5'b00000, sa ^ sb, 8'hFF, 23'd0};
            if (za || zb) return {5'b00000, sa ^ sb, 31'd0};
            return round_pack(sa ^ sb, aw * bw, (ea - 150) + (eb - 150));
        end
        if (ia && ib && (sa != sb)) return {5'b10000, 32'h7FC00000};
        if (ia) return {5'b00000, a};
        if (ib) return {5'b00000, b};
        if (za && zb) return {5'b00000, sa & sb, 31'd0};
        if (za) return {5'b00000, b};
        if (zb) return {5'b00000, a};
        lo = (ea < eb) ? ea : eb;
        aw = aw << (ea - lo);
        bw = bw << (eb - lo);
        if (sa == sb) return round_pack(sa, aw + bw, lo - 150);
        if (aw > bw)  return round_pack(sa, aw - bw, lo - 150);
        if (bw > aw)  return round_pack(sb, bw - aw, lo - 150);
        return {5'b00000, 32'd0};
    endfunction

    function automatic logic [31:0] rand_operand(input logic [31:0] other);
        logic [31:0] specials [10];
        int          e;
        specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                     32'h7FA00000, 32'h00400000, 32'h3F800000, 32'h7F7FFFFF, 32'h00800000};
        case ($urandom_range(0, 4))
            0: return $urandom();
            1: begin
                e = int'(other[30:23]) + int'($urandom_range(0, 6)) - 3;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                return {1'($urandom()), e[7:0], 23'($urandom())};
            end
            2: return specials[$urandom_range(0, 9)];
            3: begin
                e = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 20))
                                                : int'($urandom_range(235, 254));
                return {1'($urandom()), e[7:0], 23'($urandom())};
            end
            default: return {~other[31], other[30:0] ^ 31'($urandom_range(0, 7))};
        endcase
    endfunction

    task automatic test_reset();
        resetn = 1'b1; op = 1'b1; rs1 = 32'h3F800000; rs2 = 32'h3F800000;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (out !== 32'h00000000) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h, want 00000000", i, out);
            end
`ifdef FP_MUL_ADD_FLAGS_EN
            n_tests++;
            if (flags !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: got %b, want 00000", i, flags);
            end
`endif
        end
        resetn = 1'b0;
        step();
        n_tests++;
        if (out !== 32'h3F800000) begin
            n_fail++;
            $display("FAIL reset_release: got %h, want 3f800000", out);
        end
    endtask

    // Directed table entries: {op, rs1, rs2, expected out}
    task automatic run_table(input string name, input logic [96:0] tbl [$]);
        foreach (tbl[i]) begin
            op = tbl[i][96]; rs1 = tbl[i][95:64]; rs2 = tbl[i][63:32];
            step();
            n_tests++;
            if (out !== tbl[i][31:0]) begin
                n_fail++;
                $display("FAIL %s[%0d] a=%h b=%h: got %h, want %h",
                         name, i, rs1, rs2, out, tbl[i][31:0]);
            end
        end
    endtask

    task automatic test_mul();
        logic [96:0] t [$];
        t = '{{1'b1, 32'h3FC00000, 32'h40000000, 32'h40400000},
              {1'b1, 32'h3F000000, 32'hC0800000, 32'hC0000000}};
        run_table("mul", t);
    endtask

    task automatic test_add();
        logic [96:0] t [$];
        t = '{{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000},
              {1'b0, 32'h40000000, 32'hBF000000, 32'h3FC00000},
              {1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000},
              {1'b0, 32'h80000000, 32'h80000000, 32'h80000000}};
        run_table("add", t);
    endtask

    task automatic test_rounding();
        logic [96:0] t [$];
        t = '{{1'b0, 32'h4B800000, 32'h3F800000, 32'h4B800000},
              {1'b0, 32'h4B800001, 32'h3F800000, 32'h4B800002}};
        run_table("round", t);
    endtask

    task automatic test_specials();
        logic [96:0] t [$];
        t = '{{1'b1, 32'h7F800000, 32'h00000000, 32'h7FC00000},
              {1'b1, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000},
              {1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000},
              {1'b1, 32'h00400000, 32'h3F800000, 32'h00000000}};
        run_table("special", t);
    endtask

`ifdef FP_MUL_ADD_FLAGS_EN
    task automatic test_flags();
        logic [68:0] t [3];
        t = '{{32'h7F7FFFFF, 32'h40000000, 5'b00101},
              {32'h7F800000, 32'h00000000, 5'b10000},
              {32'h3FC00000, 32'h40000000, 5'b00000}};
        foreach (t[i]) begin
            op = 1'b1; rs1 = t[i][68:37]; rs2 = t[i][36:5];
            step();
            n_tests++;
            if (flags !== t[i][4:0]) begin
                n_fail++;
                $display("FAIL flags[%0d]: got %b, want %b", i, flags, t[i][4:0]);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [36:0] expv;
        for (int i = 0; i < 3000; i++) begin
            op  = 1'($urandom());
            rs1 = rand_operand($urandom());
            rs2 = rand_operand(rs1);
            expv = ref_model(op, rs1, rs2);
            step();
            n_tests++;
            if (out !== expv[31:0]) begin
                n_fail++;
                $display("FAIL random op=%0d a=%h b=%h: got %h, want %h",
                         op, rs1, rs2, out, expv[31:0]);
            end
`ifdef FP_MUL_ADD_FLAGS_EN
            n_tests++;
            if (flags !== expv[36:32]) begin
                n_fail++;
                $display("FAIL random_flags op=%0d a=%h b=%h: got %b, want %b",
                         op, rs1, rs2, flags, expv[36:32]);
            end
`endif
        end
    endtask

    // Alternating ops every cycle with occasional reset pulses overriding the operation
    task automatic test_back_to_back();
        logic [36:0] expv;
        for (int i = 0; i < 300; i++) begin
            op     = 1'(i);
            resetn = ($urandom_range(0, 15) == 0);
            rs1    = rand_operand($urandom());
            rs2    = rand_operand(rs1);
            expv   = resetn ? 37'd0 : ref_model(op, rs1, rs2);
            step();
            n_tests++;
            if (out !== expv[31:0]) begin
                n_fail++;
                $display("FAIL b2b rst=%0d op=%0d a=%h b=%h: got %h, want %h",
                         resetn, op, rs1, rs2, out, expv[31:0]);
            end
        end
        resetn = 1'b0;
    endtask

    initial begin
        resetn = 1'b1; op = 1'b0; rs1 = '0; rs2 = '0;
        test_reset();
        test_mul();
        test_add();
        test_rounding();
        test_specials();
`ifdef FP_MUL_ADD_FLAGS_EN
        test_flags();
`endif
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mul_add.md
Name: fp_mul_add

Overview:
- Single-precision IEEE 754 arithmetic unit that computes either the product or the sum of two binary32 operands, selected per cycle.
- Output is registered.
- Serves as the shared multiply/add element for iterative datapaths in the float unit, e.g. the Newton-Raphson reciprocal/divide chain, which cascades instances with constant operands such as 2.0 and 48/17.

Parameters:
- None; the format is fixed at binary32.

Ports:
clk  input  1  rising-edge clock
resetn  input  1  synchronous reset, active-high despite the name; a 1 sampled at a rising edge clears state
op  input  1  0 = add (rs1 + rs2), 1 = multiply (rs1 * rs2)
rs1  input  32  operand A, binary32 {sign, exp[7:0], frac[22:0]}
rs2  input  32  operand B, binary32; subtraction is done by the caller flipping bit 31
out  output  32  registered binary32 result

Behaviour:
- Reset: when resetn=1 at a rising edge, out <= 32'h00000000. Reset overrides any operation in that cycle. Output is 0 from the next edge until a non-reset edge.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on out after edge N. No handshake. A new operation is accepted every cycle and the combinational path is rs1/rs2/op -> out register.
- Subnormals: subnormal inputs (exp=0, frac!=0) are treated as signed zero. Results below 2^-126 flush to signed zero.
- Rounding: round-to-nearest, ties-to-even, using guard/round/sticky bits.
- Multiply:
  - sign = s1^s2.
  - exp = e1+e2-127 with 10-bit signed intermediate.
  - 24x24 significand product (hidden bit 1), normalised by at most 1 bit.
  - A rounding carry out renormalises and increments exp.
  - Biased exp >= 255 after rounding gives a signed infinity. Biased exp <= 0 gives signed zero.
- Add:
  - Swap so |A| >= |B|.
  - Align B right by exp difference, saturating at 26. Shifted-out bits OR into sticky.
  - Add or subtract significands.
  - Leading-zero normalise left (up to 24), or 1-bit right on carry.
  - Round, then apply the same overflow/underflow rules as multiply.
  - Exact cancellation gives +0. -0 + -0 gives -0.
- Special cases (both ops):
  - Any NaN input gives canonical NaN 32'h7FC00000.
  - Multiply: Inf*0 gives NaN. Inf*finite gives signed Inf. 0*finite gives signed zero.
  - Add: +Inf + -Inf gives NaN. Inf + x gives that Inf. x + 0 gives x, with a flushed-subnormal result giving signed zero.
- op may change every cycle. No internal state other than the output register, and the flag register when enabled.

Optional Feature:
- Macro: FP_MUL_ADD_FLAGS_EN.
- When defined:
  - Adds output port flags[4:0] = {NV, DZ, OF, UF, NX}, registered alongside out with the same 1-cycle latency.
  - flags resets to 0.
  - NV is set for an invalid op (Inf*0, Inf-Inf, signalling NaN input).
  - DZ is always 0.
  - OF is set on overflow to Inf.
  - UF is set on flush-to-zero of a nonzero result.
  - NX is set when any discarded bit is nonzero, or with OF/UF.
- When undefined: no flags port and no flag logic.
- Result values are identical in both builds.

Test Plan:
- Reset then release: resetn=1 for 2 cycles with rs1=32'h3F800000, rs2=32'h3F800000 -> out=32'h00000000. Release with op=1 -> out=32'h3F800000 after next edge.
- Multiply normal: op=1, rs1=32'h3FC00000 (1.5), rs2=32'h40000000 (2.0) -> out=32'h40400000 one cycle later. Back-to-back op=1, rs1=32'h3F000000, rs2=32'hC0800000 -> out=32'hC0000000 on the following cycle.
- Add/subtract: op=0, 32'h3F800000 + 32'h40000000 -> 32'h40400000. 32'h40000000 + 32'hBF000000 -> 32'h3FC00000. 32'h3F800000 + 32'hBF800000 -> 32'h00000000.
- Rounding: op=0, 32'h4B800000 (2^24) + 32'h3F800000 (1.0) -> 32'h4B800000 (tie to even). 32'h4B800001 + 32'h3F800000 -> 32'h4B800002.
- Specials: op=1, 32'h7F800000 * 32'h00000000 -> 32'h7FC00000. op=1, 32'h7F7FFFFF * 32'h40000000 -> 32'h7F800000. op=0, 32'h7F800000 + 32'hFF800000 -> 32'h7FC00000. op=1, 32'h00400000 * 32'h3F800000 -> 32'h00000000.
- Flags build: with FP_MUL_ADD_FLAGS_EN defined, overflow case -> flags=5'b00101. Inf*0 -> flags=5'b10000. 1.5*2.0 -> flags=5'b00000.
